// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - running argmax over a serial frame of signed scores
// Optional: define ARGMAX_SCORE_EN to add score_out carrying the winning score.
module argmax_classifier #(
   parameter int IN_WIDTH    = 16,
   parameter int NUM_CLASSES = 10,
   parameter int IDX_WIDTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  data_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [IDX_WIDTH-1:0] class_out,
`ifdef ARGMAX_SCORE_EN
   output logic [IN_WIDTH-1:0]  score_out,
`endif
   output logic                 out_valid,
   input  logic                 out_ready
);

   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

   state_t               state_q, state_d;
   logic [IDX_WIDTH-1:0] count_q, count_d;
   logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
   logic [IDX_WIDTH-1:0] class_q, class_d;
   logic [IN_WIDTH-1:0]  best_val_q, best_val_d;
   logic                 accept, last_beat, take_win;

   assign accept    = in_valid && in_ready;
   assign last_beat = (count_q == LAST_IDX);
   // The first beat of a frame always wins; later ties keep the earlier index.
   assign take_win  = (count_q == '0) || ($signed(data_in) > $signed(best_val_q));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= COLLECT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: if (accept && last_beat) state_d = HOLD;
         HOLD:    if (out_ready)           state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == COLLECT);
      out_valid = (state_q == HOLD);
   end

`ifdef ARGMAX_SCORE_EN
   logic [IN_WIDTH-1:0] score_q, score_d;
   assign score_out = score_q;
`endif

   always_comb begin
      count_d    = count_q;
      best_idx_d = best_idx_q;
      best_val_d = best_val_q;
      class_d    = class_q;
`ifdef ARGMAX_SCORE_EN
      score_d    = score_q;
`endif
      if (accept) begin
         if (take_win) begin
            best_val_d = data_in;
            best_idx_d = count_q;
         end
         if (last_beat) begin
            count_d = '0;
            class_d = take_win ? count_q : best_idx_q;
`ifdef ARGMAX_SCORE_EN
            score_d = take_win ? data_in : best_val_q;
`endif
         end else begin
            count_d = count_q + 1'b1;
         end
      end
      if (state_q == HOLD && out_ready) best_val_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         best_idx_q <= '0;
         best_val_q <= '0;
         class_q    <= '0;
`ifdef ARGMAX_SCORE_EN
         score_q    <= '0;
`endif
      end else begin
         count_q    <= count_d;
         best_idx_q <= best_idx_d;
         best_val_q <= best_val_d;
         class_q    <= class_d;
`ifdef ARGMAX_SCORE_EN
         score_q    <= score_d;
`endif
      end
   end

   assign class_out = class_q;

endmodule
